// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode stage with IF/ID register, load-use stall and registered ID/EX bundle
module id_stage_pipe #(
    parameter int XLEN         = 32,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd_out,
    output logic            ex_regwrite,
    output logic            ex_memread_out,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic            ifid_valid;
    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;
    logic [CNT_W-1:0] cnt;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd_idx;
    logic            rs1_used;
    logic            rs2_used;
    logic            dec_regwrite;
    logic            dec_memread;
    logic            dec_memwrite;
    logic            dec_alusrc;
    logic            dec_illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hz;
    logic            stall;

    assign opcode   = ifid_instr[6:0];
    assign funct3   = ifid_instr[14:12];
    assign rd_idx   = ifid_instr[11:7];
    assign rs1_addr = ifid_instr[19:15];
    assign rs2_addr = ifid_instr[24:20];

    always_comb begin
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_alusrc   = 1'b1;
        dec_illegal  = 1'b0;
        imm32        = 32'h0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_regwrite = 1'b1;
                imm32        = {ifid_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_regwrite = 1'b1;
                imm32        = {{12{ifid_instr[31]}}, ifid_instr[19:12], ifid_instr[20],
                                ifid_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                rs1_used     = 1'b1;
                dec_regwrite = 1'b1;
                imm32        = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_BRANCH: begin
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
                dec_alusrc = 1'b0;
                imm32      = {{20{ifid_instr[31]}}, ifid_instr[7], ifid_instr[30:25],
                              ifid_instr[11:8], 1'b0};
            end
            OP_LOAD: begin
                rs1_used     = 1'b1;
                dec_regwrite = 1'b1;
                dec_memread  = 1'b1;
                imm32        = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_STORE: begin
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                dec_memwrite = 1'b1;
                imm32        = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            end
            OP_IMM: begin
                rs1_used     = 1'b1;
                dec_regwrite = 1'b1;
                // Shift-immediates carry funct7 in [31:25]; only the shamt is an operand.
                if (funct3[1:0] == 2'b01)
                    imm32 = {27'b0, ifid_instr[24:20]};
                else
                    imm32 = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_OP: begin
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b0;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));

    // Same-cycle WB writes are not yet visible in the RF read data.
    always_comb begin
        op1 = rf_rdata1;
        op2 = rf_rdata2;
        if (rs1_addr == 5'd0)
            op1 = '0;
        else if (wb_we && (wb_rd == rs1_addr))
            op1 = wb_wdata;
        if (rs2_addr == 5'd0)
            op2 = '0;
        else if (wb_we && (wb_rd == rs2_addr))
            op2 = wb_wdata;
    end

    assign hz = ifid_valid && ex_memread && (ex_rd != 5'd0) &&
                (((ex_rd == rs1_addr) && rs1_used) || ((ex_rd == rs2_addr) && rs2_used));
    assign stall    = hz || (cnt != '0);
    assign id_ready = !stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end else if (hz) begin
            cnt <= CNT_W'(STALL_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc    <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
        end else if (id_ready) begin
            ifid_valid <= if_valid;
            ifid_instr <= if_instr;
            ifid_pc    <= if_pc;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid       <= 1'b0;
            ex_pc          <= '0;
            ex_instr       <= 32'h0;
            ex_imm         <= '0;
            ex_rs1_data    <= '0;
            ex_rs2_data    <= '0;
            ex_rs1         <= 5'd0;
            ex_rs2         <= 5'd0;
            ex_rd_out      <= 5'd0;
            ex_regwrite    <= 1'b0;
            ex_memread_out <= 1'b0;
            ex_memwrite    <= 1'b0;
            ex_alusrc      <= 1'b0;
            ex_illegal     <= 1'b0;
        end else if (flush || stall) begin
            ex_valid       <= 1'b0;
            ex_regwrite    <= 1'b0;
            ex_memread_out <= 1'b0;
            ex_memwrite    <= 1'b0;
            ex_illegal     <= 1'b0;
        end else begin
            ex_valid       <= ifid_valid;
            ex_pc          <= ifid_pc;
            ex_instr       <= ifid_instr;
            ex_imm         <= dec_imm;
            ex_rs1_data    <= op1;
            ex_rs2_data    <= op2;
            ex_rs1         <= rs1_addr;
            ex_rs2         <= rs2_addr;
            ex_rd_out      <= rd_idx;
            ex_regwrite    <= ifid_valid && dec_regwrite;
            ex_memread_out <= ifid_valid && dec_memread;
            ex_memwrite    <= ifid_valid && dec_memwrite;
            ex_alusrc      <= ifid_valid && dec_alusrc;
            ex_illegal     <= ifid_valid && dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe with 1- and 3-bubble instances
module tb_id_stage_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        as;
        logic        il;
    } exp_t;

    localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_ADD   = 32'h001101B3; // add  x3,x2,x1
    localparam logic [31:0] I_ADD6  = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] I_BEQ   = 32'hFE000CE3; // beq  x0,x0,-8
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_SRAI  = 32'h4030D093; // srai x1,x1,3
    localparam logic [31:0] I_LUI   = 32'hABCDE0B7; // lui  x1,0xABCDE
    localparam logic [31:0] I_JAL   = 32'hFFDFF0EF; // jal  x1,-4
    localparam logic [31:0] I_SW    = 32'hFE20AE23; // sw   x2,-4(x1)

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_valid, flush, ex_memread, wb_we;
    logic [31:0] if_instr, if_pc, rf_rdata1, rf_rdata2, wb_wdata;
    logic [4:0]  ex_rd, wb_rd;

    logic        id_ready, ex_valid, ex_regwrite, ex_memread_out, ex_memwrite, ex_alusrc, ex_illegal;
    logic [4:0]  rs1_addr, rs2_addr, ex_rs1, ex_rs2, ex_rd_out;
    logic [31:0] ex_pc, ex_instr, ex_imm, ex_rs1_data, ex_rs2_data;

    logic        d3_id_ready, d3_ex_valid, d3_ex_regwrite, d3_ex_memread_out, d3_ex_memwrite;
    logic        d3_ex_alusrc, d3_ex_illegal;
    logic [4:0]  d3_rs1_addr, d3_rs2_addr, d3_ex_rs1, d3_ex_rs2, d3_ex_rd_out;
    logic [31:0] d3_ex_pc, d3_ex_instr, d3_ex_imm, d3_ex_rs1_data, d3_ex_rs2_data;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .STALL_CYCLES(1), .CNT_W(3)) dut1 (
        .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_instr(ex_instr), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd_out(ex_rd_out), .ex_regwrite(ex_regwrite),
        .ex_memread_out(ex_memread_out), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_illegal(ex_illegal)
    );

    id_stage_pipe #(.XLEN(32), .STALL_CYCLES(3), .CNT_W(3)) dut3 (
        .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(d3_id_ready), .flush(flush), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .rs1_addr(d3_rs1_addr), .rs2_addr(d3_rs2_addr), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .ex_valid(d3_ex_valid), .ex_pc(d3_ex_pc),
        .ex_instr(d3_ex_instr), .ex_imm(d3_ex_imm), .ex_rs1_data(d3_ex_rs1_data),
        .ex_rs2_data(d3_ex_rs2_data), .ex_rs1(d3_ex_rs1), .ex_rs2(d3_ex_rs2),
        .ex_rd_out(d3_ex_rd_out), .ex_regwrite(d3_ex_regwrite), .ex_memread_out(d3_ex_memread_out),
        .ex_memwrite(d3_ex_memwrite), .ex_alusrc(d3_ex_alusrc), .ex_illegal(d3_ex_illegal)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [4:0] ctl);
        exp_t e;
        e = {pc, instr, imm, rd, ctl};
        return e;
    endfunction

    function automatic exp_t obs1();
        return {ex_pc, ex_instr, ex_imm, ex_rd_out, ex_regwrite, ex_memread_out, ex_memwrite,
                ex_alusrc, ex_illegal};
    endfunction

    function automatic exp_t obs3();
        return {d3_ex_pc, d3_ex_instr, d3_ex_imm, d3_ex_rd_out, d3_ex_regwrite, d3_ex_memread_out,
                d3_ex_memwrite, d3_ex_alusrc, d3_ex_illegal};
    endfunction

    function automatic logic [179:0] all_ex1();
        return {ex_valid, ex_pc, ex_instr, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2,
                ex_rd_out, ex_regwrite, ex_memread_out, ex_memwrite, ex_alusrc, ex_illegal};
    endfunction

    function automatic logic [179:0] all_ex3();
        return {d3_ex_valid, d3_ex_pc, d3_ex_instr, d3_ex_imm, d3_ex_rs1_data, d3_ex_rs2_data,
                d3_ex_rs1, d3_ex_rs2, d3_ex_rd_out, d3_ex_regwrite, d3_ex_memread_out,
                d3_ex_memwrite, d3_ex_alusrc, d3_ex_illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; ex_memread = 0; ex_rd = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; wb_we = 0; wb_rd = 0; wb_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 0;
        step();
        step();
        rstn = 1;
        step();
        sb.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 0;
        step();
        step();
        checks++;
        if (id_ready !== 1'b1 || d3_id_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_id_ready got %b/%b want 1/1", id_ready, d3_id_ready);
        end
        checks++;
        if (all_ex1() !== '0 || all_ex3() !== '0) begin
            failures++;
            $display("FAIL reset_ex_zero got %h / %h want 0", all_ex1(), all_ex3());
        end
        rstn = 1;
        step();
        checks++;
        if (id_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_id_ready got %b want 1", id_ready);
        end
    endtask

    task automatic test_addi();
        exp_t e;
        do_reset();
        if_valid = 1; if_instr = I_ADDI; if_pc = 32'h0;
        sb.push_back(mk(32'h0, I_ADDI, 32'h5, 5'd1, 5'b10010));
        step();
        if_valid = 0;
        for (int i = 0; i < 6 && !ex_valid; i++) step();
        checks++;
        if (!ex_valid) begin
            failures++;
            $display("FAIL addi_timeout ex_valid got 0 want 1");
        end else begin
            e = sb.pop_front();
            if (obs1() !== e) begin
                failures++;
                $display("FAIL addi_bundle got %h want %h", obs1(), e);
            end
        end
    endtask

    task automatic test_stall1();
        exp_t e;
        do_reset();
        if_valid = 1; if_instr = I_ADD; if_pc = 32'h100;
        sb.push_back(mk(32'h100, I_ADD, 32'h0, 5'd3, 5'b10000));
        step();
        if_valid = 0; ex_memread = 1; ex_rd = 5'd2;
        rf_rdata1 = 32'h1111_0000; rf_rdata2 = 32'h0000_2222;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall1_hz_ready got %b want 0", id_ready);
        end
        step();
        ex_memread = 0;
        #1;
        checks++;
        if (id_ready !== 1'b1 || ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall1_bubble ready/valid got %b/%b want 1/0", id_ready, ex_valid);
        end
        step();
        checks++;
        if (!ex_valid) begin
            failures++;
            $display("FAIL stall1_issue ex_valid got 0 want 1");
        end else begin
            e = sb.pop_front();
            if (obs1() !== e || ex_rs1_data !== 32'h1111_0000 || ex_rs2_data !== 32'h0000_2222) begin
                failures++;
                $display("FAIL stall1_bundle got %h %h %h want %h 11110000 00002222",
                         obs1(), ex_rs1_data, ex_rs2_data, e);
            end
        end
    endtask

    task automatic test_stall3();
        exp_t e;
        int low;
        int bubbles;
        do_reset();
        if_valid = 1; if_instr = I_ADD; if_pc = 32'h100;
        sb.push_back(mk(32'h100, I_ADD, 32'h0, 5'd3, 5'b10000));
        step();
        // Next instruction stays presented on IF for the whole stall.
        if_instr = I_ADDI; if_pc = 32'h104;
        sb.push_back(mk(32'h104, I_ADDI, 32'h5, 5'd1, 5'b10010));
        ex_memread = 1; ex_rd = 5'd2;
        #1;
        low = 0;
        bubbles = 0;
        for (int k = 0; k < 10; k++) begin
            if (d3_id_ready) break;
            low++;
            checks++;
            if (d3_rs1_addr !== 5'd2 || d3_rs2_addr !== 5'd1) begin
                failures++;
                $display("FAIL stall3_ifid_hold rs1/rs2 got %0d/%0d want 2/1", d3_rs1_addr, d3_rs2_addr);
            end
            step();
            if (!d3_ex_valid) bubbles++;
            ex_memread = 0;
            #1;
        end
        checks++;
        if (low != 3 || bubbles != 3) begin
            failures++;
            $display("FAIL stall3_count low/bubbles got %0d/%0d want 3/3", low, bubbles);
        end
        for (int k = 0; k < 6 && sb.size() != 0; k++) begin
            step();
            if_valid = 0;
            if (d3_ex_valid) begin
                e = sb.pop_front();
                checks++;
                if (obs3() !== e) begin
                    failures++;
                    $display("FAIL stall3_bundle got %h want %h", obs3(), e);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL stall3_drain left got %0d want 0", sb.size());
        end
    endtask

    task automatic test_bypass();
        do_reset();
        if_valid = 1; if_instr = I_ADD6; if_pc = 32'h40;
        step();
        if_instr = I_ADD6; if_pc = 32'h44;
        wb_we = 1; wb_rd = 5'd5; wb_wdata = 32'hDEADBEEF; rf_rdata1 = 32'h0; rf_rdata2 = 32'h12345678;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs1_data !== 32'hDEADBEEF || ex_rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL bypass_hit v/rs1/rs2 got %b/%h/%h want 1/deadbeef/00000000",
                     ex_valid, ex_rs1_data, ex_rs2_data);
        end
        if_valid = 0;
        wb_rd = 5'd0; rf_rdata1 = 32'h55;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h44 || ex_rs1_data !== 32'h55 || ex_rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL bypass_rd0 v/pc/rs1/rs2 got %b/%h/%h/%h want 1/00000044/00000055/00000000",
                     ex_valid, ex_pc, ex_rs1_data, ex_rs2_data);
        end
    endtask

    task automatic test_flush_hazard();
        exp_t e;
        do_reset();
        if_valid = 1; if_instr = I_ADD; if_pc = 32'h300;
        step();
        if_instr = I_ADDI; if_pc = 32'h304;
        flush = 1; ex_memread = 1; ex_rd = 5'd2;
        step();
        flush = 0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || d3_ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ex_valid got %b/%b want 0/0", ex_valid, d3_ex_valid);
        end
        checks++;
        if (id_ready !== 1'b1 || d3_id_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_id_ready got %b/%b want 1/1", id_ready, d3_id_ready);
        end
        sb.push_back(mk(32'h304, I_ADDI, 32'h5, 5'd1, 5'b10010));
        step();
        if_valid = 0;
        checks++;
        if (ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ifid_killed ex_valid got %b want 0", ex_valid);
        end
        step();
        checks++;
        if (!d3_ex_valid || !ex_valid) begin
            failures++;
            $display("FAIL flush_no_bubbles ex_valid got %b/%b want 1/1", ex_valid, d3_ex_valid);
        end else begin
            e = sb.pop_front();
            if (obs3() !== e || obs1() !== e) begin
                failures++;
                $display("FAIL flush_next_bundle got %h want %h", obs3(), e);
            end
        end
        ex_memread = 0;
    endtask

    task automatic test_imm_stream();
        exp_t tbl[6];
        exp_t e;
        do_reset();
        tbl[0] = mk(32'h0, I_BEQ,  32'hFFFFFFF8, 5'd25, 5'b00000);
        tbl[1] = mk(32'h0, I_ILL,  32'h00000000, 5'd0,  5'b00011);
        tbl[2] = mk(32'h0, I_SRAI, 32'h00000003, 5'd1,  5'b10010);
        tbl[3] = mk(32'h0, I_LUI,  32'hABCDE000, 5'd1,  5'b10010);
        tbl[4] = mk(32'h0, I_JAL,  32'hFFFFFFFC, 5'd1,  5'b10010);
        tbl[5] = mk(32'h0, I_SW,   32'hFFFFFFFC, 5'd28, 5'b00110);
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                if_valid = 1; if_instr = tbl[i].instr; if_pc = 32'h200 + 32'(4 * i);
                e = tbl[i];
                e.pc = if_pc;
                sb.push_back(e);
            end else begin
                if_valid = 0;
            end
            step();
            if (ex_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL imm_unexpected got pc %h want none", ex_pc);
                end else begin
                    e = sb.pop_front();
                    if (obs1() !== e) begin
                        failures++;
                        $display("FAIL imm_bundle got %h want %h", obs1(), e);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL imm_drain left got %0d want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        if_valid = 1; if_instr = I_ADD; if_pc = 32'h400;
        step();
        if_valid = 0; ex_memread = 1; ex_rd = 5'd1;
        step();
        ex_memread = 0;
        step();
        #1;
        checks++;
        if (d3_id_ready !== 1'b0) begin
            failures++;
            $display("FAIL midstall_pre ready got %b want 0", d3_id_ready);
        end
        rstn = 0;
        #1;
        checks++;
        if (d3_id_ready !== 1'b1 || all_ex3() !== '0) begin
            failures++;
            $display("FAIL midstall_reset ready/ex got %b/%h want 1/0", d3_id_ready, all_ex3());
        end
        step();
        rstn = 1;
        step();
        checks++;
        if (d3_id_ready !== 1'b1 || d3_ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL midstall_after ready/valid got %b/%b want 1/0", d3_id_ready, d3_ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_stall1();
        test_stall3();
        test_bypass();
        test_flush_hazard();
        test_imm_stream();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised RV32I decode stage with an integrated IF/ID pipeline register and a registered ID/EX output bundle.
- Decodes all immediate formats and a compact control set.
- Bypasses same-cycle WB writes into register reads.
- Detects load-use hazards and stalls IF for a parametrised number of bubbles.
- Honours a branch/jump flush from EX.
Sits between the fetch stage and the EX pipeline register.

Parameters:
XLEN, 32, datapath / PC / immediate width; immediates sign-extended to XLEN.
STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7; >1 for multi-cycle memory).
CNT_W, 3, stall counter width; must hold STALL_CYCLES-1.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an instruction
if_instr  in  32  fetched instruction
if_pc  in  XLEN  fetched PC
id_ready  out  1  IF may advance; 0 = hold PC and if_* stable
flush  in  1  EX redirect (taken branch/jump); kills IF/ID and ID/EX contents
ex_memread  in  1  instruction currently in EX is a load
ex_rd  in  5  destination of the instruction in EX
rs1_addr  out  5  RF read address 1 (from IF/ID instr[19:15])
rs2_addr  out  5  RF read address 2 (from IF/ID instr[24:20])
rf_rdata1  in  XLEN  RF read data 1 (combinational)
rf_rdata2  in  XLEN  RF read data 2 (combinational)
wb_we  in  1  WB stage writes RF this cycle
wb_rd  in  5  WB destination
wb_wdata  in  XLEN  WB write data
ex_valid  out  1  ID/EX bundle valid
ex_pc  out  XLEN  PC of the instruction
ex_instr  out  32  raw instruction
ex_imm  out  XLEN  sign-extended immediate
ex_rs1_data  out  XLEN  operand 1 (bypassed)
ex_rs2_data  out  XLEN  operand 2 (bypassed)
ex_rs1  out  5  rs1 index
ex_rs2  out  5  rs2 index
ex_rd_out  out  5  rd index
ex_regwrite  out  1  writes rd
ex_memread_out  out  1  load
ex_memwrite  out  1  store
ex_alusrc  out  1  1 = operand B is ex_imm
ex_illegal  out  1  unrecognised opcode

Behaviour:
- Reset, asynchronous on rstn low:
  - IF/ID valid = 0, stall counter = 0.
  - All ex_* outputs = 0.
  - id_ready = 1 during reset and immediately after.
- IF/ID register:
  - When id_ready=1 and flush=0, captures if_valid/if_instr/if_pc.
  - When id_ready=0, holds.
  - When flush=1, valid <= 0.
- rs1 usage: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- rs2 usage: BRANCH, STORE, OP.
- hz = IF/ID valid & ex_memread & ex_rd!=0 & ((ex_rd==rs1 & rs1 used) | (ex_rd==rs2 & rs2 used)).
- stall = hz | (cnt!=0); id_ready = !stall (combinational).
- Stall counter:
  - On hz with cnt==0: cnt <= STALL_CYCLES-1.
  - While cnt!=0 and stall: cnt decrements by 1 per cycle.
  - Total bubbles per hazard = STALL_CYCLES.
- ID/EX register, one-cycle latency from IF/ID:
  - flush: ex_valid, ex_regwrite, ex_memread_out, ex_memwrite, ex_illegal <= 0; cnt <= 0. Flush has priority over stall.
  - Else stall: bubble, with the same five bits <= 0 and other fields holding.
  - Else: load the decoded IF/ID contents, with ex_valid = IF/ID valid. When invalid, the control bits are forced to 0.
- Bypass: operand = 0 if index==0. Otherwise operand = wb_wdata if wb_we & wb_rd==index; otherwise rf_rdata.
- Immediates are sign-extended from instr[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - SLLI/SRLI/SRAI use zero-extended [24:20].
- Control by opcode:
  - regwrite: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - memread: LOAD.
  - memwrite: STORE.
  - alusrc: all except OP and BRANCH.
  - Any other opcode: ex_illegal=1, with regwrite/memread/memwrite = 0.
- Simultaneous events: flush plus hazard means flush wins and no stall follows. Reset mid-stall clears cnt; id_ready returns to 1.

Test Plan:
- Reset, then stream ADDI x1,x0,5 (0x00500093) at PC 0x0 → next cycle ex_valid=1, ex_imm=5, ex_regwrite=1, ex_alusrc=1, ex_rd_out=1.
- LW x2,0(x1) in EX (ex_memread=1, ex_rd=2) with ADD x3,x2,x1 in IF/ID, STALL_CYCLES=1 → id_ready=0 for 1 cycle, one bubble (ex_valid=0), ADD issues the following cycle.
- Same hazard with STALL_CYCLES=3 → id_ready low 3 consecutive cycles, 3 bubbles, IF/ID instr/pc unchanged throughout.
- wb_we=1, wb_rd=5, wb_wdata=0xDEADBEEF, rf_rdata1=0 while decoding ADD x6,x5,x0 → ex_rs1_data=0xDEADBEEF, ex_rs2_data=0. Same stimulus with wb_rd=0 → no bypass.
- flush=1 in the same cycle as a load-use hazard → ex_valid=0, next id_ready=1, IF/ID valid=0, no further bubbles.
- BEQ with imm=-8 (0xFE000CE3) → ex_imm=0xFFFFFFF8, ex_alusrc=0. Opcode 0x7F → ex_illegal=1, ex_regwrite=0. rstn pulsed low mid-stall → all ex_* = 0, id_ready=1.
